// File: rtl/fsm_arb_pkg.sv
// rtl/fsm_arb_pkg.sv - shared state encoding and sizing helper for the round-robin bus grant controller
//
// Purpose : 2-bit grant-flow state type plus the grant-index width helper used
//           by the interface, the arbiter and the top level.
// Ports   : none (package)
package fsm_arb_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    BBUSY = 2'b01,
    BWAIT = 2'b10,
    BFREE = 2'b11
  } state_t;

  // Width of a master index; a single-master build still carries a 1-bit id.
  function automatic int id_w(input int n_req);
    return (n_req > 1) ? $clog2(n_req) : 1;
  endfunction

endpackage

// File: rtl/fsm_rr_arb_if.sv
// rtl/fsm_rr_arb_if.sv - request/grant and target handshake bundle of the bus grant controller
//
// Purpose : groups the master request vector, the target done/dly handshake
//           and the registered grant outputs.
// Ports   : req[N_REQ], done, dly        (driven by masters / target)
//           gnt[N_REQ], gnt_id, busy, timeout (driven by the arbiter)
// Modports: master - the bus side that drives requests and handshake
//           slave  - the grant controller
interface fsm_rr_arb_if #(
  parameter int N_REQ = 4
);
  import fsm_arb_pkg::*;

  localparam int ID_W = id_w(N_REQ);

  logic [N_REQ-1:0] req;
  logic             done;
  logic             dly;
  logic [N_REQ-1:0] gnt;
  logic [ID_W-1:0]  gnt_id;
  logic             busy;
  logic             timeout;

  modport master (
    output req, done, dly,
    input  gnt, gnt_id, busy, timeout
  );

  modport slave (
    input  req, done, dly,
    output gnt, gnt_id, busy, timeout
  );

endinterface

// File: rtl/fsm_rr_arb_rr_pick.sv
// rtl/fsm_rr_arb_rr_pick.sv - combinational round-robin winner selection
//
// Purpose : picks the first set request at or after index ptr+1 (wrapping).
// Ports   : req[N_REQ] in  - request vector
//           ptr[ID_W]  in  - index of the previous winner
//           winner     out - selected index (0 when no request)
//           any_req    out - at least one request is set
module rr_pick #(
  parameter int N_REQ = 4,
  parameter int ID_W  = 2
) (
  input  logic [N_REQ-1:0] req,
  input  logic [ID_W-1:0]  ptr,
  output logic [ID_W-1:0]  winner,
  output logic             any_req
);

  logic            hi_hit;
  logic [ID_W-1:0] hi_idx;
  logic [ID_W-1:0] lo_idx;

  // Scanning downward leaves the lowest qualifying index in each candidate:
  // hi_idx is the lowest request above ptr, lo_idx the lowest overall (wrap case).
  always_comb begin
    hi_hit = 1'b0;
    hi_idx = '0;
    lo_idx = '0;
    for (int j = N_REQ - 1; j >= 0; j--) begin
      if (req[j]) begin
        lo_idx = ID_W'(j);
        if (j > int'(ptr)) begin
          hi_hit = 1'b1;
          hi_idx = ID_W'(j);
        end
      end
    end
  end

  assign winner  = hi_hit ? hi_idx : lo_idx;
  assign any_req = |req;

endmodule

// File: rtl/fsm_rr_arb.sv
// rtl/fsm_rr_arb.sv - N-master round-robin bus grant controller with busy watchdog
//
// Purpose : IDLE/BBUSY/BWAIT/BFREE grant flow, round-robin arbitration,
//           registered one-hot grant and forced release of a stalled owner.
// Ports   : clk    in  - rising-edge clock
//           rst_n  in  - asynchronous active-low reset
//           bus    slave modport: req/done/dly in, gnt/gnt_id/busy/timeout out
module fsm_rr_arb
  import fsm_arb_pkg::*;
#(
  parameter int N_REQ    = 4,
  parameter int CNT_W    = 8,
  parameter int MAX_BUSY = 200
) (
  input  logic          clk,
  input  logic          rst_n,
  fsm_rr_arb_if.slave   bus
);

  localparam int              ID_W    = id_w(N_REQ);
  localparam bit              WD_EN   = (MAX_BUSY != 0);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((MAX_BUSY > 0) ? MAX_BUSY - 1 : 0);

  state_t           state, next;
  logic [CNT_W-1:0] cnt;
  logic [ID_W-1:0]  ptr;
  logic [ID_W-1:0]  winner;
  logic             any_req;
  logic             arb;
  logic             force_rel;
  logic             hold_nxt;
  logic [ID_W-1:0]  owner_nxt;
  logic [N_REQ-1:0] gnt_nxt;

  logic [N_REQ-1:0] gnt_r;
  logic [ID_W-1:0]  gnt_id_r;
  logic             busy_r;
  logic             timeout_r;

  rr_pick #(.N_REQ(N_REQ), .ID_W(ID_W)) u_pick (
    .req     (bus.req),
    .ptr     (ptr),
    .winner  (winner),
    .any_req (any_req)
  );

  always_comb begin
    next      = IDLE;
    arb       = 1'b0;
    force_rel = 1'b0;
    case (state)
      IDLE, BFREE: begin
        if (any_req) begin
          next = BBUSY;
          arb  = 1'b1;
        end
      end
      BBUSY: begin
        // done wins over an expiring watchdog in the same cycle
        if (bus.done) begin
          next = bus.dly ? BWAIT : BFREE;
        end else if (WD_EN && cnt == CNT_LAST) begin
          next      = BFREE;
          force_rel = 1'b1;
        end else begin
          next = BBUSY;
        end
      end
      BWAIT: begin
        next = bus.dly ? BWAIT : BFREE;
      end
      default: next = IDLE;
    endcase
  end

  // Outputs are decoded from next so they appear right after the deciding edge.
  // gnt_id doubles as the frozen owner between arbitrations.
  always_comb begin
    owner_nxt = arb ? winner : gnt_id_r;
    hold_nxt  = (next == BBUSY) || (next == BWAIT);
    gnt_nxt   = '0;
    for (int j = 0; j < N_REQ; j++) begin
      gnt_nxt[j] = (owner_nxt == ID_W'(j));
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      ptr       <= ID_W'(N_REQ - 1);
      cnt       <= '0;
      gnt_r     <= '0;
      gnt_id_r  <= '0;
      busy_r    <= 1'b0;
      timeout_r <= 1'b0;
    end else begin
      state     <= next;
      timeout_r <= force_rel;
      busy_r    <= hold_nxt;
      gnt_r     <= hold_nxt ? gnt_nxt : '0;
      if (arb) begin
        ptr      <= winner;
        gnt_id_r <= winner;
        cnt      <= '0;
      end else if (state == BBUSY && cnt != '1) begin
        cnt <= cnt + 1'b1;
      end
    end
  end

  assign bus.gnt     = gnt_r;
  assign bus.gnt_id  = gnt_id_r;
  assign bus.busy    = busy_r;
  assign bus.timeout = timeout_r;

endmodule

// File: tb/tb_fsm_rr_arb.sv
// tb/tb_fsm_rr_arb.sv - directed vector bench for the round-robin bus grant controller
module tb_fsm_rr_arb;

  typedef struct {
    logic       rst_n;
    logic [3:0] req;
    logic       done;
    logic       dly;
    logic [3:0] gnt;
    logic [1:0] id;
    logic       busy;
    logic       to;
  } vec_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   errors = 0;
  int   checks = 0;
  vec_t vecs[$];

  always #5 clk = ~clk;

  fsm_rr_arb_if #(.N_REQ(4)) bus ();

  fsm_rr_arb #(.N_REQ(4), .CNT_W(8), .MAX_BUSY(5)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  function automatic vec_t v(input logic r, input logic [3:0] q, input logic d, input logic w,
                             input logic [3:0] g, input logic [1:0] i, input logic b, input logic t);
    vec_t x;
    x.rst_n = r; x.req = q; x.done = d; x.dly = w;
    x.gnt = g; x.id = i; x.busy = b; x.to = t;
    return x;
  endfunction

  task automatic chk(input string name, input int row, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s row %0d: got %0h expected %0h", name, row, got, exp);
    end
  endtask

  task automatic chk_all(input int row, input logic [3:0] g, input logic [1:0] i, input logic b, input logic t);
    chk("gnt", row, 32'(bus.gnt), 32'(g));
    chk("gnt_id", row, 32'(bus.gnt_id), 32'(i));
    chk("busy", row, 32'(bus.busy), 32'(b));
    chk("timeout", row, 32'(bus.timeout), 32'(t));
  endtask

  task automatic drive(input logic [3:0] q, input logic d, input logic w);
    bus.req = q; bus.done = d; bus.dly = w;
  endtask

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  initial begin
    drive(4'b0000, 1'b0, 1'b0);

    // basic grant then release through BFREE
    vecs.push_back(v(1, 4'b0000, 0, 0, 4'b0000, 0, 0, 0));
    vecs.push_back(v(1, 4'b0001, 0, 0, 4'b0001, 0, 1, 0));
    vecs.push_back(v(1, 4'b0000, 1, 0, 4'b0000, 0, 0, 0));
    vecs.push_back(v(1, 4'b0000, 0, 0, 4'b0000, 0, 0, 0));
    // fresh reset, all request, done every third cycle: 0,1,2,3,0
    vecs.push_back(v(0, 4'b0000, 0, 0, 4'b0000, 0, 0, 0));
    for (int k = 0; k < 5; k++) begin
      vecs.push_back(v(1, 4'b1111, 0, 0, 4'b0001 << (k % 4), 2'(k % 4), 1, 0));
      vecs.push_back(v(1, 4'b1111, 0, 0, 4'b0001 << (k % 4), 2'(k % 4), 1, 0));
      vecs.push_back(v(1, 4'b1111, 1, 0, 4'b0000, 2'(k % 4), 0, 0));
    end
    vecs.push_back(v(1, 4'b0000, 0, 0, 4'b0000, 0, 0, 0));
    // owner 2, done with dly, BWAIT longer than the watchdog limit
    vecs.push_back(v(1, 4'b0100, 0, 0, 4'b0100, 2, 1, 0));
    vecs.push_back(v(1, 4'b0000, 1, 1, 4'b0100, 2, 1, 0));
    for (int k = 0; k < 6; k++) vecs.push_back(v(1, 4'b0000, 0, 1, 4'b0100, 2, 1, 0));
    vecs.push_back(v(1, 4'b0000, 0, 0, 4'b0000, 2, 0, 0));
    vecs.push_back(v(1, 4'b0000, 0, 0, 4'b0000, 2, 0, 0));
    // watchdog: five grant cycles then forced release
    for (int k = 0; k < 5; k++) vecs.push_back(v(1, 4'b0010, 0, 0, 4'b0010, 1, 1, 0));
    vecs.push_back(v(1, 4'b0000, 0, 0, 4'b0000, 1, 0, 1));
    vecs.push_back(v(1, 4'b0000, 0, 0, 4'b0000, 1, 0, 0));
    // done on the fifth cycle beats the watchdog
    for (int k = 0; k < 4; k++) vecs.push_back(v(1, 4'b0010, 0, 0, 4'b0010, 1, 1, 0));
    vecs.push_back(v(1, 4'b0000, 0, 0, 4'b0010, 1, 1, 0));
    vecs.push_back(v(1, 4'b0000, 1, 0, 4'b0000, 1, 0, 0));
    vecs.push_back(v(1, 4'b0000, 0, 0, 4'b0000, 1, 0, 0));
    // owner 1 drops req while master 3 waits
    vecs.push_back(v(1, 4'b0010, 0, 0, 4'b0010, 1, 1, 0));
    vecs.push_back(v(1, 4'b1010, 0, 0, 4'b0010, 1, 1, 0));
    vecs.push_back(v(1, 4'b1000, 0, 0, 4'b0010, 1, 1, 0));
    vecs.push_back(v(1, 4'b1000, 1, 0, 4'b0000, 1, 0, 0));
    vecs.push_back(v(1, 4'b1000, 0, 0, 4'b1000, 3, 1, 0));
    vecs.push_back(v(1, 4'b0000, 1, 0, 4'b0000, 3, 0, 0));
    vecs.push_back(v(1, 4'b0000, 0, 0, 4'b0000, 3, 0, 0));

    // reset state
    #1;
    chk_all(-1, 4'b0000, 2'd0, 1'b0, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int r = 0; r < vecs.size(); r++) begin
      rst_n = vecs[r].rst_n;
      drive(vecs[r].req, vecs[r].done, vecs[r].dly);
      step();
      chk_all(r, vecs[r].gnt, vecs[r].id, vecs[r].busy, vecs[r].to);
    end
    rst_n = 1'b1;

    // asynchronous reset in the middle of BWAIT (ptr is 3 here)
    drive(4'b0100, 1'b0, 1'b0);
    step();
    chk_all(100, 4'b0100, 2'd2, 1'b1, 1'b0);
    drive(4'b0000, 1'b1, 1'b1);
    step();
    chk_all(101, 4'b0100, 2'd2, 1'b1, 1'b0);
    drive(4'b0000, 1'b0, 1'b1);
    #2;
    rst_n = 1'b0;
    #1;
    chk_all(102, 4'b0000, 2'd0, 1'b0, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    drive(4'b1001, 1'b0, 1'b0);
    step();
    chk_all(103, 4'b0001, 2'd0, 1'b1, 1'b0);
    drive(4'b1001, 1'b1, 1'b0);
    step();
    chk_all(104, 4'b0000, 2'd0, 1'b0, 1'b0);
    drive(4'b1001, 1'b0, 1'b0);
    step();
    chk_all(105, 4'b1000, 2'd3, 1'b1, 1'b0);
    drive(4'b0000, 1'b1, 1'b0);
    step();
    chk_all(106, 4'b0000, 2'd3, 1'b0, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/fsm_rr_arb.md
Name: fsm_rr_arb

Overview:
Parametrised multi-master bus grant controller. It keeps the IDLE/BBUSY/BWAIT/BFREE grant flow and adds three things: N requesters with round-robin arbitration, a one-hot registered grant, and a busy-timeout watchdog that forces release of a stalled owner. It sits between N bus masters and the shared-bus handshake (done/dly) driven by the target side.

Parameters:
N_REQ, 4, number of requesters (legal range 1..16)
CNT_W, 8, width of the busy-timeout counter
MAX_BUSY, 200, cycles allowed in BBUSY before forced release; 0 disables the watchdog (must be < 2**CNT_W)

Ports:
clk  in  1  single clock, rising edge
rst_n  in  1  asynchronous, active-low reset
req  in  N_REQ  request vector, bit i = master i
done  in  1  current transfer complete
dly  in  1  target requests a wait phase after done
gnt  out  N_REQ  registered one-hot grant
gnt_id  out  max(1,$clog2(N_REQ))  index of the granted master; valid while busy=1
busy  out  1  registered, 1 in BBUSY or BWAIT
timeout  out  1  registered one-cycle pulse on a forced release

Behaviour:
- Reset (async, rst_n=0): state=IDLE, gnt=0, gnt_id=0, busy=0, timeout=0, cnt=0, ptr=N_REQ-1 (master 0 has first priority).
- States (2-bit): IDLE=00, BBUSY=01, BWAIT=10, BFREE=11.
- IDLE: if |req, next=BBUSY and the winner is latched; otherwise stay in IDLE.
- BBUSY:
  - done=1 and dly=1 -> BWAIT.
  - done=1 and dly=0 -> BFREE.
  - Otherwise, if MAX_BUSY!=0 and cnt==MAX_BUSY-1 -> BFREE and timeout pulse.
  - Otherwise stay in BBUSY.
  - done has priority over the timeout in the same cycle.
- BWAIT: dly=0 -> BFREE; otherwise stay. The watchdog is not active in BWAIT.
- BFREE: always lasts exactly one cycle.
  - |req -> BBUSY with a new arbitration, so back-to-back ownership is possible.
  - Otherwise -> IDLE.
- Arbitration (combinational, evaluated only when next=BBUSY from IDLE/BFREE):
  - Search starts at index ptr+1 mod N_REQ; the first set req bit wins.
  - ptr <= winner at the transition.
  - Result: a continuously requesting master cannot win twice in a row while another master requests.
- Outputs are decoded from next, not state, so they are registered with zero extra latency:
  - req sampled high at edge k in IDLE -> gnt/busy valid right after edge k.
  - next in BBUSY/BWAIT: gnt=onehot(owner), gnt_id=owner, busy=1.
  - next in IDLE/BFREE: gnt=0, busy=0. gnt_id holds its last value.
- Owner is frozen from BBUSY entry until BFREE. Changes on req (including the owner dropping req) do not affect the current grant; only done/dly/timeout end it.
- cnt: cleared on every entry to BBUSY, increments each cycle in BBUSY, saturates, and holds outside BBUSY.
- timeout=1 for exactly the cycle after the forced BBUSY->BFREE edge.
- N_REQ=1: the arbiter degenerates to a pass-through and gnt_id is constant 0.
- X handling: the next-state default is IDLE (no x-assignment). Unreachable encodings go to IDLE.
- Reset asserted mid-transfer clears gnt asynchronously. No handshake completion is owed.

Decomposition:
- Package fsm_arb_pkg: 2-bit state constants IDLE/BBUSY/BWAIT/BFREE and a state typedef.
- Sub-module rr_pick (combinational): inputs req[N_REQ], ptr. Outputs winner index and any_req.
- The top level holds the state register, next-state logic, counter, and output registers.

Test Plan:
- Reset then req=4'b0001 at cycle 2 -> gnt=0001, gnt_id=0, busy=1 after that edge. done=1, dly=0 for one cycle -> BFREE, gnt=0000, then IDLE.
- req=4'b1111 held constant, done pulsed every 3rd cycle -> grant order 0,1,2,3,0, with one BFREE cycle (gnt=0) between grants.
- Owner 2 in BBUSY, done=1 with dly=1 for 4 cycles -> BWAIT with gnt=0100 held; dly=0 -> BFREE, then gnt=0.
- MAX_BUSY=5, req=0010, done never asserted -> gnt=0010 for exactly 5 cycles, then timeout=1 for one cycle and gnt=0. With done=1 on that 5th cycle -> no timeout pulse.
- Owner 1 drops req mid-BBUSY while req[3]=1 -> gnt stays 0010 until done; then master 3 is granted after BFREE.
- rst_n driven low asynchronously mid-BWAIT (between clock edges) -> gnt=0 and busy=0 immediately. After release, req=1000 and 0001 together -> master 0 is granted first.
